duty_ramp: RTL and testbench

- Slew-rate limiter that drives the `duty` input of the edge-aligned PWM generator.
- Accepts a target duty over a valid/ready handshake.
- Walks its `duty` output toward the target in bounded steps at a programmable rate, so the PWM never sees step jumps (soft start / soft stop).
- Sits directly upstream of the PWM block; its `duty` output connects straight to that block's `duty` input.

---
 rtl/duty_ramp_pkg.sv | 15 +
 rtl/duty_ramp_if.sv | 15 +
 rtl/duty_ramp_tick_gen.sv | 37 +++
 rtl/duty_ramp.sv | 93 +++++++++
 tb/tb_duty_ramp.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/duty_ramp_pkg.sv
// Shared definitions for the duty ramp and the PWM block it drives.
// Holds the default duty width (which must agree with the PWM block), the
// default divider width, and the ramp FSM state encoding.
package duty_ramp_pkg;
  localparam int DUTY_WIDTH_DEF = 8;
  localparam int DIV_WIDTH_DEF  = 16;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RAMP = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_RAMP = ST_RAMP
  } ramp_state_e;
endpackage

// File: rtl/duty_ramp_if.sv
// Target handshake between a duty source and the ramp.
//   target        requested duty
//   target_valid  target present (source drives)
//   target_ready  ramp can accept (ramp drives)
// The source uses the master modport; the ramp uses the slave modport.
interface duty_ramp_if #(
  parameter int DUTY_WIDTH = duty_ramp_pkg::DUTY_WIDTH_DEF
);
  logic [DUTY_WIDTH-1:0] target;
  logic                  target_valid;
  logic                  target_ready;

  modport master (output target, output target_valid, input  target_ready);
  modport slave  (input  target, input  target_valid, output target_ready);
endinterface

// File: rtl/duty_ramp_tick_gen.sv
// Step-interval prescaler for the duty ramp.
//   clk, rst  clock, async active-low reset
//   en        count this cycle (ramp running and enabled)
//   clr       restart the interval from zero
//   tick_div  clocks per step; 0 behaves as 1
//   tick      high in the cycle whose edge applies a step
module ramp_tick_gen
  import duty_ramp_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] tick_div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] presc_q, presc_d;
  logic [DIV_WIDTH-1:0] last;

  always_comb begin
    // Terminal count is tick_eff-1; a zero divider maps to tick_eff=1.
    last    = (tick_div == '0) ? '0 : tick_div - DIV_WIDTH'(1);
    // >= rather than == so that shrinking tick_div mid-interval fires at
    // once instead of wrapping through the whole counter range.
    tick    = en & (presc_q >= last);
    presc_d = presc_q;
    if (clr)     presc_d = '0;
    else if (en) presc_d = tick ? '0 : presc_q + DIV_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
  end
endmodule

// File: rtl/duty_ramp.sv
// Slew-rate limiter feeding the PWM duty input.
//   clk, rst      clock, async active-low reset
//   enable        1 = ramp runs, 0 = everything freezes
//   tick_div      clocks per step (0 behaves as 1)
//   tgt_if        target handshake (slave side); ready == enable
//   duty          registered duty to the PWM
//   busy          high while ramping
//   done          one-cycle pulse when duty reaches the accepted target
module duty_ramp
  import duty_ramp_pkg::*;
#(
  parameter int DUTY_WIDTH = DUTY_WIDTH_DEF,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int STEP       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  tick_div,
  duty_ramp_if.slave            tgt_if,
  output logic [DUTY_WIDTH-1:0] duty,
  output logic                  busy,
  output logic                  done
);
  localparam logic [DUTY_WIDTH:0] STEP_W = (DUTY_WIDTH+1)'(STEP);

  ramp_state_e           state_q;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d, target_q, eff_tgt, step_duty;
  logic                  done_q;
  logic                  xfer, tick;
  logic [DUTY_WIDTH:0]   diff_s, diff_abs, stepv;

  assign tgt_if.target_ready = enable;
  assign xfer = tgt_if.target_valid & enable;

  ramp_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .en       (enable & (state_q == S_RAMP)),
    .clr      (xfer & (state_q == S_IDLE)),
    .tick_div (tick_div),
    .tick     (tick)
  );

  always_comb begin
    // A target accepted on this edge already steers a step on the same edge.
    eff_tgt   = xfer ? tgt_if.target : target_q;
    // One extra bit: the MSB is the sign, so the magnitude never wraps.
    diff_s    = {1'b0, eff_tgt} - {1'b0, duty_q};
    diff_abs  = diff_s[DUTY_WIDTH] ? -diff_s : diff_s;
    stepv     = (diff_abs > STEP_W) ? STEP_W : diff_abs;
    // stepv <= distance to target, so neither direction can overshoot or wrap.
    step_duty = diff_s[DUTY_WIDTH] ? duty_q - stepv[DUTY_WIDTH-1:0]
                                   : duty_q + stepv[DUTY_WIDTH-1:0];
    duty_d    = tick ? step_duty : duty_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (enable) begin
        if (xfer) target_q <= tgt_if.target;
        case (state_q)
          S_IDLE: begin
            if (xfer) begin
              if (tgt_if.target == duty_q) done_q  <= 1'b1;
              else                         state_q <= S_RAMP;
            end
          end
          S_RAMP: begin
            duty_q <= duty_d;
            // Covers both landing on the target and a retarget onto the
            // current duty; an abandoned target simply never matches.
            if (duty_d == eff_tgt) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign duty = duty_q;
  assign busy = (state_q == S_RAMP);
  assign done = done_q;
endmodule

// File: tb/tb_duty_ramp.sv
module tb_duty_ramp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst_n = 2'b11;
  logic        en[2];
  logic [15:0] div[2];
  logic [7:0]  tg[2];
  logic        vl[2];
  logic [7:0]  duty[2];
  logic        busy[2], done[2], rdy[2];

  int checks = 0;
  int failures = 0;

  duty_ramp_if #(.DUTY_WIDTH(8)) if0 ();
  duty_ramp_if #(.DUTY_WIDTH(8)) if1 ();
  assign if0.target = tg[0];
  assign if0.target_valid = vl[0];
  assign rdy[0] = if0.target_ready;
  assign if1.target = tg[1];
  assign if1.target_valid = vl[1];
  assign rdy[1] = if1.target_ready;

  duty_ramp #(.DUTY_WIDTH(8), .DIV_WIDTH(16), .STEP(1)) u_dut0 (
    .clk(clk), .rst(rst_n[0]), .enable(en[0]), .tick_div(div[0]),
    .tgt_if(if0.slave), .duty(duty[0]), .busy(busy[0]), .done(done[0]));
  duty_ramp #(.DUTY_WIDTH(8), .DIV_WIDTH(16), .STEP(16)) u_dut1 (
    .clk(clk), .rst(rst_n[1]), .enable(en[1]), .tick_div(div[1]),
    .tgt_if(if1.slave), .duty(duty[1]), .busy(busy[1]), .done(done[1]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int stepv(input int i);
    return (i == 0) ? 1 : 16;
  endfunction

  // Reference model: integer duty walked toward target by min(STEP,|diff|)
  // every tick_eff enabled edges.
  int m_duty[2], m_tgt[2], m_pc[2];
  bit m_busy[2], m_done[2];

  function automatic void mreset(input int i);
    m_duty[i] = 0; m_tgt[i] = 0; m_pc[i] = 0; m_busy[i] = 0; m_done[i] = 0;
  endfunction

  function automatic void mstep(input int i);
    int te, d, mv;
    bit nd;
    nd = 0;
    if (!rst_n[i]) begin mreset(i); return; end
    if (en[i]) begin
      te = (div[i] == 0) ? 1 : int'(div[i]);
      if (!m_busy[i]) begin
        if (vl[i]) begin
          m_tgt[i] = int'(tg[i]); m_pc[i] = 0;
          if (m_tgt[i] == m_duty[i]) nd = 1; else m_busy[i] = 1;
        end
      end else begin
        if (vl[i]) m_tgt[i] = int'(tg[i]);
        if (m_pc[i] >= te - 1) begin
          m_pc[i] = 0;
          d  = m_tgt[i] - m_duty[i];
          mv = (d < 0) ? -d : d;
          if (mv > stepv(i)) mv = stepv(i);
          m_duty[i] += (d < 0) ? -mv : mv;
        end else m_pc[i]++;
        if (m_duty[i] == m_tgt[i]) begin nd = 1; m_busy[i] = 0; end
      end
    end
    m_done[i] = nd;
  endfunction

  always @(posedge clk) for (int i = 0; i < 2; i++) mstep(i);
  always @(negedge rst_n[0]) mreset(0);
  always @(negedge rst_n[1]) mreset(1);

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_duty", i), int'(duty[i]), m_duty[i]);
      chk($sformatf("m%0d_busy", i), int'(busy[i]), int'(m_busy[i]));
      chk($sformatf("m%0d_done", i), int'(done[i]), int'(m_done[i]));
      chk($sformatf("m%0d_rdy", i),  int'(rdy[i]),  int'(en[i]));
    end
  end

  typedef struct {
    bit en; int div; bit vl; int tg;
    int e_duty; bit e_busy; bit e_done;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit e, int dv, bit v, int t, int ed, bit eb, bit edn);
    vec_t r;
    r.en = e; r.div = dv; r.vl = v; r.tg = t;
    r.e_duty = ed; r.e_busy = eb; r.e_done = edn;
    return r;
  endfunction

  // Transfer t to DUT i from a known start and follow every step.
  task automatic ramp_run(input int i, input int start, input int t,
                          input int tdiv, input string nm);
    int exp_q[$];
    int d, mv, idx, cyc, prev, te, bound;
    bit seen_done;
    d = start;
    while (d != t) begin
      mv = (t > d) ? t - d : d - t;
      if (mv > stepv(i)) mv = stepv(i);
      d += (t > d) ? mv : -mv;
      exp_q.push_back(d);
    end
    te = (tdiv == 0) ? 1 : tdiv;
    bound = te * (exp_q.size() + 2) + 10;
    div[i] = 16'(tdiv); tg[i] = 8'(t); vl[i] = 1'b1;
    @(negedge clk); #1 vl[i] = 1'b0;
    idx = 0; cyc = 0; prev = start; seen_done = 0;
    while (!seen_done && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (int'(duty[i]) != prev) begin
        chk({nm, "_val"}, int'(duty[i]), (idx < exp_q.size()) ? exp_q[idx] : -1);
        chk({nm, "_at"}, cyc, te * (idx + 1));
        idx++;
        prev = int'(duty[i]);
      end
      if (done[i]) begin
        seen_done = 1;
        chk({nm, "_done_duty"}, int'(duty[i]), t);
      end
    end
    chk({nm, "_steps"}, idx, exp_q.size());
    chk({nm, "_done_seen"}, int'(seen_done), 1);
    #1;
  endtask

  int n, ndone, cyc;
  bit hit;

  initial begin
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b1; div[i] = 16'd1; tg[i] = 8'd0; vl[i] = 1'b0;
    end
    #1 rst_n = 2'b00;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_duty", int'(duty[i]), 0);
      chk("rst_busy", int'(busy[i]), 0);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_rdy",  int'(rdy[i]),  1);
    end
    #1 rst_n = 2'b11;
    repeat (3) @(negedge clk);
    chk("idle_duty", int'(duty[0]), 0);
    chk("idle_busy", int'(busy[0]), 0);
    #1;

    // Unit up-ramp, equal-target in IDLE, tick_div=0 on DUT0 (STEP=1).
    tbl.push_back(mk(1, 1, 1, 8, 0, 1, 0));
    for (int j = 1; j <= 8; j++) tbl.push_back(mk(1, 1, 0, 0, j, j < 8, j == 8));
    tbl.push_back(mk(1, 1, 0, 0, 8, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8, 8, 0, 1));
    tbl.push_back(mk(1, 1, 0, 0, 8, 0, 0));
    tbl.push_back(mk(1, 0, 1, 10, 8, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 9, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0, 10, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 10, 0, 0));
    for (int k = 0; k < tbl.size(); k++) begin
      en[0] = tbl[k].en; div[0] = 16'(tbl[k].div);
      vl[0] = tbl[k].vl; tg[0] = 8'(tbl[k].tg);
      @(negedge clk);
      chk($sformatf("tbl%0d_duty", k), int'(duty[0]), tbl[k].e_duty);
      chk($sformatf("tbl%0d_busy", k), int'(busy[0]), int'(tbl[k].e_busy));
      chk($sformatf("tbl%0d_done", k), int'(done[0]), int'(tbl[k].e_done));
      #1;
    end
    vl[0] = 1'b0;

    // Clamped coarse ramp on DUT1 (STEP=16), both directions.
    ramp_run(1, 0, 255, 100, "up16");
    ramp_run(1, 255, 0, 100, "dn16");

    // Retarget reversal at duty 64.
    ndone = 0; hit = 0;
    div[1] = 16'd1; tg[1] = 8'd192; vl[1] = 1'b1;
    @(negedge clk); #1 vl[1] = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (done[1]) ndone++;
      if (duty[1] == 8'd64) hit = 1;
    end
    chk("rt_reach64", int'(hit), 1);
    #1 tg[1] = 8'd32; vl[1] = 1'b1;
    @(negedge clk);
    chk("rt_duty48", int'(duty[1]), 48);
    if (done[1]) ndone++;
    #1 vl[1] = 1'b0;
    @(negedge clk);
    chk("rt_duty32", int'(duty[1]), 32);
    chk("rt_done32", int'(done[1]), 1);
    chk("rt_idle", int'(busy[1]), 0);
    if (done[1]) ndone++;
    repeat (5) begin @(negedge clk); if (done[1]) ndone++; end
    chk("rt_ndone", ndone, 1);
    #1;

    // Freeze mid-interval on DUT0 (STEP=1, tick_div=4), resume.
    div[0] = 16'd4; tg[0] = 8'd200; vl[0] = 1'b1;
    @(negedge clk); #1 vl[0] = 1'b0;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (duty[0] == 8'd40) hit = 1;
    end
    chk("frz_reach40", int'(hit), 1);
    @(negedge clk);
    chk("frz_pre", int'(duty[0]), 40);
    #1 en[0] = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      chk("frz_duty", int'(duty[0]), 40);
      chk("frz_rdy", int'(rdy[0]), 0);
      chk("frz_busy", int'(busy[0]), 1);
    end
    #1 en[0] = 1'b1;
    cyc = 0; hit = 0;
    while (!hit && cyc < 20) begin
      @(negedge clk); cyc++;
      if (duty[0] != 8'd40) hit = 1;
    end
    chk("frz_resume_at", cyc, 3);
    chk("frz_resume_val", int'(duty[0]), 41);

    // Asynchronous reset mid-ramp at duty 100.
    hit = 0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      if (duty[0] == 8'd100) hit = 1;
    end
    chk("ar_reach100", int'(hit), 1);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("ar_duty", int'(duty[0]), 0);
    chk("ar_busy", int'(busy[0]), 0);
    @(negedge clk); #1 rst_n[0] = 1'b1;

    // Randomized traffic on both instances against the model.
    for (n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        en[i] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 19) == 0) div[i] = 16'($urandom_range(0, 5));
        vl[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) tg[i] = 8'(m_duty[i]);
        else tg[i] = 8'($urandom_range(0, 255));
      end
      @(negedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
